// File: rtl/imem_readback_tx.sv
// -----------------------------------------------------------------------------
// imem_readback_tx
//
// Bootloader readback path. On an accepted start request it reads `count`
// 32-bit words from instruction memory, beginning at word address 0, and
// streams them to the shared uart_tx byte interface as a framed dump:
//
//   header  {16'h0, 8'(count), HDR_TAG}
//   data    IMEM[0] .. IMEM[count-1]
//   trailer sum of the data words mod 2^32 (0 when count = 0)
//
// Every word goes out least-significant byte first. The host uses the dump to
// confirm a program was loaded correctly before the core is released.
//
// Parameters
//   ADDR_W   IMEM word-address width; depth = 2**ADDR_W words
//   HDR_TAG  tag carried in header byte 0
//
// Ports
//   clk          in   system clock
//   rst          in   asynchronous reset, active-high
//   i_start      in   one-cycle start request, ignored while o_busy = 1
//   i_num_words  in   words to dump, sampled on accepted start, clamped to depth
//   o_rd_en      out  IMEM read strobe, one cycle per word
//   o_rd_addr    out  IMEM word address
//   i_rd_data    in   IMEM read data, valid the cycle after o_rd_en
//   o_tx_data    out  byte to uart_tx (meaningful only while o_tx_dv = 1)
//   o_tx_dv      out  byte request to uart_tx
//   i_tx_active  in   uart_tx busy flag
//   o_busy       out  high from accepted start until (and including) o_done
//   o_done       out  one-cycle pulse when the dump completes
// -----------------------------------------------------------------------------
module imem_readback_tx #(
    parameter int          ADDR_W  = 6,
    parameter logic [7:0]  HDR_TAG = 8'h04
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic [ADDR_W:0]   i_num_words,
    output logic              o_rd_en,
    output logic [ADDR_W-1:0] o_rd_addr,
    input  logic [31:0]       i_rd_data,
    output logic [7:0]        o_tx_data,
    output logic              o_tx_dv,
    input  logic              i_tx_active,
    output logic              o_busy,
    output logic              o_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_RD,
        S_RDW,
        S_DATA,
        S_CSUM,
        S_FIN
    } state_t;

    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] ONE   = {{ADDR_W{1'b0}}, 1'b1};

    state_t          state_q, state_d;
    logic [ADDR_W:0] count_q;      // clamped word count for this dump
    logic [ADDR_W:0] addr_q;       // one bit wider than the IMEM address so
                                   // the "last word" compare never wraps
    logic [31:0]     word_q;       // word currently being serialised
    logic [31:0]     csum_q;
    logic [1:0]      byte_idx_q;
    logic            tx_dv_q;
    logic [7:0]      tx_data_q;

    logic [ADDR_W:0] num_clamped;
    logic            tx_state;
    logic            byte_ack;
    logic            last_byte;
    logic            last_word;

    assign num_clamped = (i_num_words > DEPTH) ? DEPTH : i_num_words;

    // States in which the byte engine serialises word_q.
    assign tx_state  = (state_q == S_HDR) || (state_q == S_DATA) || (state_q == S_CSUM);
    // uart_tx has taken the pending byte.
    assign byte_ack  = tx_dv_q && i_tx_active;
    assign last_byte = byte_ack && (byte_idx_q == 2'd3);
    assign last_word = (addr_q + ONE) == count_q;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // -------------------------------------------------------------------------
    // Next-state and combinational outputs
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: defaults first so no path through the case leaves a signal
        // unassigned, which would infer a latch.
        state_d = state_q;
        o_rd_en = 1'b0;
        o_done  = 1'b0;

        unique case (state_q)
            S_IDLE: if (i_start) state_d = S_HDR;
            S_HDR: begin
                if (last_byte) state_d = (count_q == '0) ? S_CSUM : S_RD;
            end
            S_RD: begin
                o_rd_en = 1'b1;
                state_d = S_RDW;
            end
            S_RDW: state_d = S_DATA;
            S_DATA: begin
                if (last_byte) state_d = last_word ? S_CSUM : S_RD;
            end
            S_CSUM: if (last_byte) state_d = S_FIN;
            S_FIN: begin
                // Let the final byte leave the serializer before reporting done.
                if (!i_tx_active) begin
                    o_done  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign o_busy    = (state_q != S_IDLE);
    assign o_rd_addr = addr_q[ADDR_W-1:0];
    assign o_tx_dv   = tx_dv_q;
    assign o_tx_data = tx_data_q;

    // -------------------------------------------------------------------------
    // Datapath: count, address, checksum, word register and byte engine
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q    <= '0;
            addr_q     <= '0;
            word_q     <= '0;
            csum_q     <= '0;
            byte_idx_q <= '0;
            tx_dv_q    <= 1'b0;
            tx_data_q  <= '0;
        end else begin
            if (state_q == S_IDLE && i_start) begin
                count_q    <= num_clamped;
                addr_q     <= '0;
                csum_q     <= '0;
                byte_idx_q <= '0;
                word_q     <= {16'h0, 8'(num_clamped), HDR_TAG};
            end

            if (state_q == S_RDW) begin
                word_q <= i_rd_data;
                csum_q <= csum_q + i_rd_data;
            end

            // Byte handshake: raise a request only when the UART is idle and
            // nothing is pending, hold it until the UART reports active, then
            // drop it and move to the next byte.
            if (tx_state) begin
                if (!tx_dv_q && !i_tx_active) begin
                    tx_dv_q   <= 1'b1;
                    tx_data_q <= word_q[{byte_idx_q, 3'b000} +: 8];
                end else if (byte_ack) begin
                    tx_dv_q    <= 1'b0;
                    byte_idx_q <= byte_idx_q + 2'd1;
                end
            end

            if (state_q == S_DATA && last_byte) addr_q <= addr_q + ONE;

            // The checksum is complete once the last data word has been
            // captured, so the trailer can be loaded as the last byte of the
            // preceding word goes out.
            if (last_byte &&
                ((state_q == S_HDR && count_q == '0) || (state_q == S_DATA && last_word)))
                word_q <= csum_q;
        end
    end

endmodule

// File: tb/tb_imem_readback_tx.sv
// -----------------------------------------------------------------------------
// tb_imem_readback_tx
//
// Self-checking bench for imem_readback_tx. A reference model builds each
// expected frame as a byte list straight from the frame rules (header, data
// words LSB first, arithmetic sum trailer) and pushes it into a scoreboard
// queue. A UART model accepts bytes with programmable latency; on each
// acceptance it pops the queue and compares, and while waiting it checks that
// the request and data stay stable. Side monitors count IMEM reads per
// address and o_done pulses.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_imem_readback_tx;

    localparam int ADDR_W = 6;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst;
    logic              i_start;
    logic [ADDR_W:0]   i_num_words;
    logic              o_rd_en;
    logic [ADDR_W-1:0] o_rd_addr;
    logic [31:0]       i_rd_data;
    logic [7:0]        o_tx_data;
    logic              o_tx_dv;
    logic              i_tx_active;
    logic              o_busy;
    logic              o_done;

    imem_readback_tx #(.ADDR_W(ADDR_W), .HDR_TAG(8'h04)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_start     (i_start),
        .i_num_words (i_num_words),
        .o_rd_en     (o_rd_en),
        .o_rd_addr   (o_rd_addr),
        .i_rd_data   (i_rd_data),
        .o_tx_data   (o_tx_data),
        .o_tx_dv     (o_tx_dv),
        .i_tx_active (i_tx_active),
        .o_busy      (o_busy),
        .o_done      (o_done)
    );

    always #10 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [DEPTH];
    int          rd_cnt [DEPTH];
    int          total_rd = 0;
    int          done_cnt = 0;
    logic [7:0]  exp_q [$];
    int          lat  = 0;       // cycles from request to UART accept
    int          rand_lat = 0;   // when set, latency drawn per byte

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // IMEM model: synchronous read, data valid the cycle after the strobe.
    always @(posedge clk) if (o_rd_en) i_rd_data <= mem[o_rd_addr];

    always @(negedge clk) begin
        if (o_rd_en) begin
            rd_cnt[o_rd_addr] = rd_cnt[o_rd_addr] + 1;
            total_rd = total_rd + 1;
        end
        if (o_done) done_cnt = done_cnt + 1;
    end

    // Reference model: the frame as a byte list.
    task automatic push_word(input logic [31:0] w);
        for (int b = 0; b < 4; b++) exp_q.push_back(8'((w >> (8 * b)) & 32'hFF));
    endtask

    task automatic expect_frame(input int n);
        int          cnt;
        logic [31:0] sum;
        cnt = (n > DEPTH) ? DEPTH : n;
        sum = 32'h0;
        push_word({16'h0, 8'(cnt), 8'h04});
        for (int i = 0; i < cnt; i++) begin
            push_word(mem[i]);
            sum = sum + mem[i];
        end
        push_word(sum);
    endtask

    // UART model and byte monitor.
    initial begin
        logic [7:0] b;
        int         l, hold;
        logic       aborted;
        i_tx_active = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst && o_tx_dv && !i_tx_active) begin
                b       = o_tx_data;
                l       = rand_lat ? $urandom_range(0, 6) : lat;
                aborted = 1'b0;
                for (int k = 0; k < l; k++) begin
                    @(negedge clk);
                    if (rst) begin aborted = 1'b1; break; end
                    check("tx_dv_hold", 32'(o_tx_dv), 32'h1);
                    check("tx_data_hold", 32'(o_tx_data), 32'(b));
                end
                if (!aborted) begin
                    i_tx_active = 1'b1;
                    check("byte_expected", 32'(exp_q.size() != 0), 32'h1);
                    if (exp_q.size() != 0) check("tx_byte", 32'(b), 32'(exp_q.pop_front()));
                    hold = $urandom_range(1, 3);
                    for (int k = 0; k < hold; k++) begin
                        @(negedge clk);
                        if (rst) break;
                    end
                    i_tx_active = 1'b0;
                end
            end
        end
    end

    task automatic clear_reads();
        for (int i = 0; i < DEPTH; i++) rd_cnt[i] = 0;
        total_rd = 0;
    endtask

    task automatic pulse_start(input int n);
        @(negedge clk);
        i_start     = 1'b1;
        i_num_words = (ADDR_W + 1)'(n);
        @(negedge clk);
        i_start     = 1'b0;
    endtask

    // Issue one dump, wait for completion (bounded), then check the frame
    // was fully consumed and o_done pulsed exactly once.
    task automatic run_dump(input int n, input bit extra_start);
        int d0;
        bit seen;
        clear_reads();
        d0 = done_cnt;
        expect_frame(n);
        pulse_start(n);
        check("busy_after_start", 32'(o_busy), 32'h1);
        if (extra_start) begin
            repeat (30) @(negedge clk);
            pulse_start($urandom_range(1, 5));
        end
        seen = 1'b0;
        for (int c = 0; c < 20000; c++) begin
            @(negedge clk);
            if (done_cnt != d0) begin seen = 1'b1; break; end
        end
        check("done_seen", 32'(seen), 32'h1);
        repeat (40) @(negedge clk);
        check("done_pulses", 32'(done_cnt - d0), 32'h1);
        check("frame_drained", 32'(exp_q.size()), 32'h0);
        check("idle_after_done", 32'(o_busy), 32'h0);
        check("no_stray_dv", 32'(o_tx_dv), 32'h0);
    endtask

    initial begin
        rst         = 1'b1;
        i_start     = 1'b0;
        i_num_words = '0;
        for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
        clear_reads();
        repeat (3) @(negedge clk);
        check("rst_dv", 32'(o_tx_dv), 32'h0);
        check("rst_rd_en", 32'(o_rd_en), 32'h0);
        check("rst_busy", 32'(o_busy), 32'h0);
        check("rst_done", 32'(o_done), 32'h0);
        check("rst_addr", 32'(o_rd_addr), 32'h0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Two-word dump with known contents.
        mem[0] = 32'h11223344;
        mem[1] = 32'hAABBCCDD;
        lat = 0;
        run_dump(2, 1'b0);
        check("t2_reads", 32'(total_rd), 32'd2);

        // Empty dump: header plus zero trailer, no reads.
        run_dump(0, 1'b0);
        check("t3_no_reads", 32'(total_rd), 32'd0);

        // Checksum wraps past 2^32.
        mem[0] = 32'hFFFFFFFF;
        mem[1] = 32'h00000002;
        run_dump(2, 1'b0);

        // Slow UART, and a second start while busy must be ignored.
        lat = 5;
        mem[2] = $urandom;
        run_dump(3, 1'b1);
        lat = 0;

        // Oversized count clamps to the full depth, each address read once.
        for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
        rand_lat = 1;
        run_dump(100, 1'b0);
        check("t6_total_reads", 32'(total_rd), 32'(DEPTH));
        for (int i = 0; i < DEPTH; i++) check("t6_addr_read_once", 32'(rd_cnt[i]), 32'h1);

        // Random dumps.
        for (int r = 0; r < 4; r++) begin
            int n;
            n = $urandom_range(0, DEPTH + 2);
            run_dump(n, 1'b0);
            check("rand_reads", 32'(total_rd), 32'((n > DEPTH) ? DEPTH : n));
        end

        // Reset in the middle of a frame.
        begin
            int target;
            bit reached;
            expect_frame(10);
            target  = exp_q.size() - 7;
            pulse_start(10);
            reached = 1'b0;
            for (int c = 0; c < 5000; c++) begin
                @(negedge clk);
                if (exp_q.size() <= target && o_tx_dv) begin reached = 1'b1; break; end
            end
            check("t1_reached_mid_frame", 32'(reached), 32'h1);
            rst = 1'b1;
            #1;
            check("t1_dv_drop", 32'(o_tx_dv), 32'h0);
            check("t1_rd_en_drop", 32'(o_rd_en), 32'h0);
            check("t1_busy_drop", 32'(o_busy), 32'h0);
            check("t1_done_drop", 32'(o_done), 32'h0);
            exp_q.delete();
            repeat (3) @(negedge clk);
            rst = 1'b0;
            repeat (3) @(negedge clk);
            check("t1_addr_after", 32'(o_rd_addr), 32'h0);
            check("t1_busy_after", 32'(o_busy), 32'h0);
            check("t1_dv_after", 32'(o_tx_dv), 32'h0);
        end

        // Recovery after the abort.
        run_dump(5, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
